// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the load path: widths, load funct3 encodings,
// load FSM states and the misalignment/illegal-encoding check.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } load_state_t;

  // High for reserved funct3 encodings or an access not aligned to its size.
  function automatic logic load_illegal(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LB, F3_LBU: load_illegal = 1'b0;
      F3_LH, F3_LHU: load_illegal = off[0];
      F3_LW:         load_illegal = |off;
      default:       load_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the addressed byte/halfword/word from an aligned memory word and
// sign- or zero-extends it according to the RV32I load type.
module load_extend
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Non-pipelined RV32I load unit: one load in flight, word-aligned memory read
// over valid/ready, result extended and handed to the writeback mem operand.
module load_unit
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] addr_in,
  input  logic [2:0]      funct3,
  input  logic [REGW-1:0] rd_in,
  output logic            busy,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic [REGW-1:0] load_rd,
  output logic            misaligned
);

  load_state_t     state_q, state_d;
  logic [1:0]      offset_q;
  logic [2:0]      funct3_q;
  logic [REGW-1:0] rd_q;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] load_data_q;
  logic [REGW-1:0] load_rd_q;
  logic [XLEN-1:0] ext_data;
  logic            accept;
  logic            bad_load;
  logic            capture;

  assign accept   = (state_q == IDLE) && start;
  assign bad_load = load_illegal(funct3, addr_in[1:0]);
  // Responses outside WAIT (incl. the handshake cycle) never reach the result.
  assign capture  = (state_q == WAIT) && mem_rsp_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = bad_load ? ERR : REQ;
      REQ:     if (mem_req_ready) state_d = WAIT;
      WAIT:    if (mem_rsp_valid) state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != IDLE);
    mem_req_valid = (state_q == REQ);
    load_valid    = (state_q == DONE);
    misaligned    = (state_q == ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset_q   <= '0;
      funct3_q   <= '0;
      rd_q       <= '0;
      req_addr_q <= '0;
    end else if (accept) begin
      offset_q <= addr_in[1:0];
      funct3_q <= funct3;
      rd_q     <= rd_in;
      if (!bad_load) begin
        req_addr_q <= {addr_in[XLEN-1:2], 2'b00};
      end
    end
  end

  load_extend u_extend (
    .word   (mem_rsp_data),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_data_q <= '0;
      load_rd_q   <= '0;
    end else if (capture) begin
      load_data_q <= ext_data;
      load_rd_q   <= rd_q;
    end
  end

  assign mem_req_addr = req_addr_q;
  assign load_data    = load_data_q;
  assign load_rd      = load_rd_q;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: expected results are queued when a load is
// issued and compared when load_valid pulses.
module tb_load_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr_in;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        busy;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        load_valid;
  logic [31:0] load_data;
  logic [4:0]  load_rd;
  logic        misaligned;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_data_q[$];
  logic [4:0]  exp_rd_q[$];
  logic [31:0] last_data = 32'h0;

  always #5 clk = ~clk;

  load_unit dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .addr_in       (addr_in),
    .funct3        (funct3),
    .rd_in         (rd_in),
    .busy          (busy),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_rd       (load_rd),
    .misaligned    (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] w);
    logic [31:0] sh;
    sh = w >> (8 * a[1:0]);
    case (f3)
      3'b000:  model = {{24{sh[7]}}, sh[7:0]};
      3'b001:  model = {{16{sh[15]}}, sh[15:0]};
      3'b100:  model = {24'h0, sh[7:0]};
      3'b101:  model = {16'h0, sh[15:0]};
      default: model = w;
    endcase
  endfunction

  // Scoreboard side: every load_valid pulse pops one expected result.
  always @(negedge clk) begin
    if (!reset && load_valid) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_load_valid", 32'(load_valid), 32'd0);
      end else begin
        logic [31:0] ed;
        logic [4:0]  er;
        ed = exp_data_q.pop_front();
        er = exp_rd_q.pop_front();
        $display("load done: rd=%0d data=0x%08h (exp rd=%0d data=0x%08h)",
                 load_rd, load_data, er, ed);
        chk("load_data", load_data, ed);
        chk("load_rd", 32'(load_rd), 32'(er));
      end
    end
  end

  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] w, input int rdy_dly, input int rsp_dly,
                         input bit early, input bit restart);
    int          cyc;
    logic [31:0] exp_addr;
    exp_addr  = {a[31:2], 2'b00};
    last_data = model(f3, a, w);
    exp_data_q.push_back(last_data);
    exp_rd_q.push_back(rd);
    start = 1'b1; addr_in = a; funct3 = f3; rd_in = rd;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    // Scramble the inputs so only captured values can produce the right result.
    addr_in = 32'hFFFF_FFFF; funct3 = F3_LB; rd_in = ~rd;
    chk("busy_c1", 32'(busy), 32'd1);
    for (int i = 0; i < rdy_dly; i++) begin
      chk("req_valid_hold", 32'(mem_req_valid), 32'd1);
      chk("req_addr_hold", mem_req_addr, exp_addr);
      if (restart && i == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cyc++;
    end
    chk("req_valid", 32'(mem_req_valid), 32'd1);
    chk("req_addr", mem_req_addr, exp_addr);
    mem_req_ready = 1'b1;
    if (early) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = ~w;
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; cyc++;
    chk("req_valid_drop", 32'(mem_req_valid), 32'd0);
    for (int i = 0; i < rsp_dly; i++) begin
      @(posedge clk); #1;
      cyc++;
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = w;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; cyc++;
    while (!load_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(3 + rdy_dly + rsp_dly));
    @(posedge clk); #1;
    chk("load_valid_one_cycle", 32'(load_valid), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic do_err(input logic [2:0] f3, input logic [31:0] a);
    start = 1'b1; addr_in = a; funct3 = f3; rd_in = 5'd9;
    @(posedge clk); #1;
    start = 1'b0;
    chk("err_misaligned_c1", 32'(misaligned), 32'd1);
    chk("err_req_valid_c1", 32'(mem_req_valid), 32'd0);
    chk("err_busy_c1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk("err_misaligned_c2", 32'(misaligned), 32'd0);
    chk("err_req_valid_c2", 32'(mem_req_valid), 32'd0);
    chk("err_busy_c2", 32'(busy), 32'd0);
    chk("err_data_kept", load_data, last_data);
    $display("error load: funct3=%03b addr=0x%08h", f3, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic [31:0] a;
    f3_tab[0] = F3_LB; f3_tab[1] = F3_LH; f3_tab[2] = F3_LW;
    f3_tab[3] = F3_LBU; f3_tab[4] = F3_LHU;

    reset = 1'b1; start = 1'b0; addr_in = '0; funct3 = '0; rd_in = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_rd", 32'(load_rd), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed extraction cases on word 0x80FF1234.
    do_load(F3_LB,  32'h0000_1003, 5'd5,  32'h80FF_1234, 0, 0, 1'b0, 1'b0);
    do_load(F3_LHU, 32'h0000_1002, 5'd6,  32'h80FF_1234, 0, 0, 1'b0, 1'b0);
    do_load(F3_LH,  32'h0000_1002, 5'd7,  32'h80FF_1234, 0, 0, 1'b0, 1'b0);
    do_load(F3_LW,  32'h0000_1000, 5'd8,  32'h80FF_1234, 0, 0, 1'b0, 1'b0);
    do_load(F3_LBU, 32'h0000_1001, 5'd9,  32'h80FF_1234, 0, 0, 1'b0, 1'b0);
    do_load(F3_LB,  32'h0000_1000, 5'd10, 32'h80FF_1234, 0, 0, 1'b0, 1'b0);

    // Error path: misaligned word, misaligned half, reserved funct3.
    do_err(F3_LW, 32'h0000_1002);
    do_err(F3_LH, 32'h0000_1001);
    do_err(3'b011, 32'h0000_1000);
    do_err(3'b110, 32'h0000_1000);

    // Request back-pressure with a stray start while busy, then a slow response.
    do_load(F3_LHU, 32'h0000_2002, 5'd11, 32'hCAFE_BABE, 3, 0, 1'b0, 1'b1);
    do_load(F3_LB,  32'h0000_2001, 5'd12, 32'hCAFE_BABE, 0, 2, 1'b0, 1'b0);

    // Response in the handshake cycle must be ignored.
    do_load(F3_LW, 32'h0000_3000, 5'd13, 32'h1122_3344, 0, 0, 1'b1, 1'b0);

    for (int k = 0; k < 10; k++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      a  = $urandom;
      if (f3 == F3_LW) a[1:0] = 2'b00;
      else if (f3 == F3_LH || f3 == F3_LHU) a[0] = 1'b0;
      do_load(f3, a, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Asynchronous reset while waiting for the response.
    start = 1'b1; addr_in = 32'h0000_4000; funct3 = F3_LW; rd_in = 5'd14;
    @(posedge clk); #1;
    start = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("async_rst_req_addr", mem_req_addr, 32'd0);
    chk("async_rst_load_data", load_data, 32'd0);
    chk("async_rst_load_rd", 32'(load_rd), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; last_data = 32'h0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_load_valid", 32'(load_valid), 32'd0);
      chk("post_rst_load_data", load_data, 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
    end
    $display("reset in WAIT: late response dropped");

    // A load after the reset still completes normally.
    do_load(F3_LHU, 32'h0000_5000, 5'd15, 32'h0BAD_F00D, 1, 1, 1'b0, 1'b0);

    chk("scoreboard_drained", 32'(exp_data_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
